// File: rtl/pal_sync_analyzer.sv
// Sinclair PAL sync analyzer: rebuilds hpos/vpos from the hsync/vsync pair,
// measures line/frame length, detects 48K vs 128K timing and reports lock.
// Ports: clk, rst_n (sync, active low), hsync, vsync (active high) in;
//        hpos, vpos, line_len, frame_lines, locked, timing_128k out.
module pal_sync_analyzer #(
    parameter int HSYNC_POS  = 344,
    parameter int VSYNC_LINE = 248,
    parameter int LOCK_LINES = 4,
    parameter int MIN_LINE   = 400,
    parameter int MAX_LINE   = 511,
    parameter int MIN_FRAME  = 300,
    parameter int MAX_FRAME  = 320,
    parameter int LEN_128K   = 456
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync,
    input  logic       vsync,
    output logic [8:0] hpos,
    output logic [8:0] vpos,
    output logic [9:0] line_len,
    output logic [8:0] frame_lines,
    output logic       locked,
    output logic       timing_128k
);

    localparam logic [9:0] MINL  = 10'(MIN_LINE);
    localparam logic [9:0] MAXL  = 10'(MAX_LINE);
    localparam logic [8:0] MINF  = 9'(MIN_FRAME);
    localparam logic [8:0] MAXF  = 9'(MAX_FRAME);
    localparam logic [9:0] L128  = 10'(LEN_128K);
    localparam logic [8:0] HPOS1 = 9'(HSYNC_POS + 1);
    localparam logic [8:0] VLINE = 9'(VSYNC_LINE);
    localparam logic [3:0] LOCKN = 4'(LOCK_LINES);

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    state_t     state;
    logic       hsync_d;
    logic       vsync_d;
    logic [9:0] lcnt;
    logic [9:0] ref_len;
    logic [8:0] fcnt;
    logic [3:0] stable;
    logic       frame_ok;

    logic hrise;
    logic vrise;
    logic line_ok;
    logic frame_in;
    logic hwrap;
    logic vlast;

    assign hrise    = hsync & ~hsync_d;
    assign vrise    = vsync & ~vsync_d;
    assign line_ok  = (lcnt >= MINL) && (lcnt <= MAXL);
    assign frame_in = (fcnt >= MINF) && (fcnt <= MAXF);

    // The free-running wrap only exists once the line length is trusted.
    assign hwrap = ~hrise & locked &
                   ({1'b0, hpos} == line_len - 10'd1);
    assign vlast = locked & (vpos == frame_lines - 9'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Syncs held high across reset must not look like a rise.
            hsync_d     <= 1'b1;
            vsync_d     <= 1'b1;
            lcnt        <= '0;
            fcnt        <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            frame_ok    <= 1'b0;
            hpos        <= '0;
            vpos        <= '0;
        end else begin
            hsync_d <= hsync;
            vsync_d <= vsync;

            if (hrise) begin
                line_len <= lcnt;
                lcnt     <= 10'd1;
            end else if (lcnt != '1) begin
                lcnt <= lcnt + 10'd1;
            end

            if (vrise) begin
                frame_lines <= fcnt;
                fcnt        <= hrise ? 9'd1 : 9'd0;
                frame_ok    <= frame_in;
            end else if (hrise && fcnt != '1) begin
                fcnt <= fcnt + 9'd1;
            end

            if (hrise) begin
                hpos <= HPOS1;
            end else if (hwrap) begin
                hpos <= '0;
            end else if (hpos != '1) begin
                hpos <= hpos + 9'd1;
            end

            if (vrise) begin
                vpos <= VLINE;
            end else if (hwrap) begin
                if (vlast) begin
                    vpos <= '0;
                end else if (vpos != '1) begin
                    vpos <= vpos + 9'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= SEARCH;
            stable      <= '0;
            ref_len     <= '0;
            locked      <= 1'b0;
            timing_128k <= 1'b0;
        end else begin
            unique case (state)
                SEARCH: begin
                    if (hrise && line_ok) begin
                        state   <= VERIFY;
                        stable  <= 4'd1;
                        ref_len <= lcnt;
                    end
                end
                VERIFY: begin
                    if (hrise) begin
                        if (lcnt == ref_len) begin
                            // Saturate so a late frame_ok still sees a match.
                            if (stable != LOCKN) begin
                                stable <= stable + 4'd1;
                            end
                        end else if (line_ok) begin
                            stable  <= 4'd1;
                            ref_len <= lcnt;
                        end else begin
                            state  <= SEARCH;
                            stable <= '0;
                        end
                    end else if (stable == LOCKN && frame_ok) begin
                        state       <= LOCKED;
                        locked      <= 1'b1;
                        timing_128k <= (ref_len == L128);
                    end
                end
                LOCKED: begin
                    if ((hrise && lcnt != ref_len) ||
                        (lcnt > MAXL) ||
                        (vrise && !frame_in)) begin
                        state       <= SEARCH;
                        stable      <= '0;
                        locked      <= 1'b0;
                        timing_128k <= 1'b0;
                    end
                end
                default: begin
                    state       <= SEARCH;
                    stable      <= '0;
                    locked      <= 1'b0;
                    timing_128k <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pal_sync_analyzer.sv
// Bench for pal_sync_analyzer on a scaled raster (48/56 clk lines,
// 32/31 line frames) driven by a behavioural sync generator.
module tb_pal_sync_analyzer;

    localparam int HS   = 36;
    localparam int VS   = 24;
    localparam int L128 = 56;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic [9:0] line_len;
    logic [8:0] frame_lines;
    logic       locked;
    logic       timing_128k;

    pal_sync_analyzer #(
        .HSYNC_POS (HS),
        .VSYNC_LINE(VS),
        .LOCK_LINES(4),
        .MIN_LINE  (40),
        .MAX_LINE  (63),
        .MIN_FRAME (28),
        .MAX_FRAME (36),
        .LEN_128K  (L128)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hsync      (hsync),
        .vsync      (vsync),
        .hpos       (hpos),
        .vpos       (vpos),
        .line_len   (line_len),
        .frame_lines(frame_lines),
        .locked     (locked),
        .timing_128k(timing_128k)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // generator
    int hc = 0, vc = 0;
    int llen = 48, nlines = 32, cur_len = 48;
    bit hmask = 0;
    bit corrupt_pend = 0;
    int corrupt_len = 0;
    bit pend_sw = 0;
    int pend_len = 0, pend_lines = 0;

    // reference model
    int cyc = 0;
    int last_hr = -1;
    int exp_len = 0;
    int hr_cnt = 0;
    int exp_frame = 0;
    bit ph = 1, pv = 1;
    bit just_hr = 0;
    int vr_after = 0;
    bit settled = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic disrupt();
        settled  = 0;
        vr_after = 0;
    endtask

    task automatic tick();
        bit hr, vr;
        hr = rst_n && hsync && !ph;
        vr = rst_n && vsync && !pv;
        just_hr = hr;
        if (vr) begin
            exp_frame = hr_cnt;
            hr_cnt    = 0;
            vr_after++;
        end
        if (hr) begin
            if (last_hr >= 0) exp_len = cyc - last_hr;
            last_hr = cyc;
            if (hr_cnt < 511) hr_cnt++;
        end
        ph = rst_n ? hsync : 1'b1;
        pv = rst_n ? vsync : 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        hc++;
        if (hc >= cur_len) begin
            hc = 0;
            vc++;
            if (vc >= nlines) begin
                vc = 0;
                if (pend_sw) begin
                    llen    = pend_len;
                    nlines  = pend_lines;
                    pend_sw = 0;
                    disrupt();
                end
            end
            cur_len = llen;
            if (corrupt_pend) begin
                cur_len      = corrupt_len;
                corrupt_pend = 0;
                disrupt();
            end
        end
        hsync = !hmask && hc >= HS && hc < HS + 4;
        vsync = vc >= VS && vc < VS + 4;
        if (!settled && vr_after >= 2 && hc == 0 && vc == 0)
            settled = 1;
        if (settled) begin
            check("locked", 32'(locked), 1);
            check("hpos", 32'(hpos), hc);
            check("vpos", 32'(vpos), vc);
            check("line_len", 32'(line_len), exp_len);
            check("frame_lines", 32'(frame_lines), exp_frame);
            check("t128", 32'(timing_128k), 32'(exp_len == L128));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_hpos"}, 32'(hpos), 0);
        check({tag, "_vpos"}, 32'(vpos), 0);
        check({tag, "_len"}, 32'(line_len), 0);
        check({tag, "_frm"}, 32'(frame_lines), 0);
        check({tag, "_lock"}, 32'(locked), 0);
        check({tag, "_t128"}, 32'(timing_128k), 0);
    endtask

    task automatic settle();
        int frames;
        frames = $urandom_range(2, 1);
        for (int i = 0; i < 12000 && !settled; i++) tick();
        repeat (frames * llen * nlines) tick();
    endtask

    task automatic wait_lock(input string tag);
        for (int i = 0; i < 2600 && !locked; i++) tick();
        check(tag, 32'(locked), 1);
    endtask

    task automatic corrupt();
        int L;
        do L = $urandom_range(63, 40); while (L == llen);
        corrupt_len  = L;
        corrupt_pend = 1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (just_hr && exp_len == L) break;
        end
        check("bad_unlock", 32'(locked), 0);
        check("bad_len", 32'(line_len), L);
        wait_lock("bad_relock");
        check("bad_t128", 32'(timing_128k), 32'(llen == L128));
    endtask

    task automatic timeout();
        int m;
        m = $urandom_range(640, 590);
        for (int i = 0; i < 200 && hc != 0; i++) tick();
        disrupt();
        hmask = 1;
        for (int i = 0; i < m; i++) begin
            tick();
            if (cyc - last_hr == 64)
                check("to_hold", 32'(locked), 1);
            if (cyc - last_hr == 65) begin
                check("to_drop", 32'(locked), 0);
                check("to_t128", 32'(timing_128k), 0);
            end
        end
        check("to_hsat", 32'(hpos), 511);
        hmask = 0;
        disrupt();
        for (int i = 0; i < 200; i++) begin
            tick();
            if (just_hr) break;
        end
        check("to_len", 32'(line_len), exp_len);
    endtask

    task automatic switch_mode(input int len, input int lines);
        pend_len   = len;
        pend_lines = lines;
        pend_sw    = 1;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (just_hr && exp_len == len) break;
        end
        check("sw_unlock", 32'(locked), 0);
        wait_lock("sw_relock");
        check("sw_t128", 32'(timing_128k), 32'(len == L128));
    endtask

    task automatic mid_reset();
        int r, n;
        r = $urandom_range(2, 0);
        for (int i = 0; i < 4000; i++) begin
            if (vc == 10 && hc == HS + 1 + r) break;
            tick();
        end
        disrupt();
        rst_n = 0;
        tick();
        check_zero("mrst");
        rst_n   = 1;
        last_hr = -1;
        hr_cnt  = 0;
        n = 0;
        do begin
            tick();
            n++;
            if (!just_hr) check("rel_hpos", 32'(hpos), n);
        end while (!just_hr && n < 200);
        check("rel_len", 32'(line_len), n - 1);
        check("rel_vpos", 32'(vpos), 0);
        disrupt();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 0;
        tick();
        tick();
        check_zero("rst");
        rst_n = 1;
        disrupt();
        settle();
        corrupt();
        settle();
        timeout();
        settle();
        switch_mode(L128, 31);
        settle();
        mid_reset();
        settle();
        switch_mode(48, 32);
        settle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
